// File: rtl/scnn_pkg.sv
// ----------------------------------------------------------------------------
// scnn_pkg
// Shared types and constants for the SCNN processing-element scheduler.
//   sched_state_t : scheduler FSM states
//   TILE          : lanes per operand side of the multiplier array
//   IP_MAX/WT_MAX : largest non-zero input / weight counts per PE
//   PIPE_LAT      : cycles from tile issue to last scatter write
//   IP_IDX_W/WT_IDX_W : widths of input / weight slot indices
// ----------------------------------------------------------------------------
package scnn_pkg;

    localparam int TILE     = 4;
    localparam int IP_MAX   = 16;
    localparam int WT_MAX   = 9;
    localparam int PIPE_LAT = 2;

    localparam int IP_IDX_W = 5;
    localparam int WT_IDX_W = 4;
    localparam int DRAIN_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        REDUCE,
        DONE
    } sched_state_t;

endpackage

// File: rtl/scnn_lane_mask.sv
// ----------------------------------------------------------------------------
// scnn_lane_mask
// Combinational lane-valid mask for one operand side of a tile.
//   base_i  : first compressed slot of the tile
//   count_i : number of valid (non-zero) slots
//   mask_o  : bit k set when base_i + k < count_i
// ----------------------------------------------------------------------------
module scnn_lane_mask
    import scnn_pkg::*;
#(
    parameter int W = IP_IDX_W
) (
    input  logic [W-1:0]    base_i,
    input  logic [W-1:0]    count_i,
    output logic [TILE-1:0] mask_o
);

    // Two guard bits keep base+k from wrapping at the top of the index range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        mask_o = '0;
        for (int k = 0; k < TILE; k++) begin
            mask_o[k] = ({2'b00, base_i} + (W+2)'(k)) < {2'b00, count_i};
        end
    end

endmodule

// File: rtl/scnn_pe_sched.sv
// ----------------------------------------------------------------------------
// scnn_pe_sched
// Sequencing controller for the SCNN processing element. Walks the
// inputs x weights Cartesian product in TILE x TILE tiles (weights inner,
// inputs outer), tracks coordinate offsets, drains the multiply/scatter
// pipeline, then pulses the accumulator reduction and completion.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : begin one pass (accepted in IDLE only)
//   num_nz_ips, num_nz_wts   : non-zero counts, latched on start
//   last_ip_ind, last_wt_ind : last decoded indices from the coordinate unit
//   issue_ready              : datapath accepts the presented tile
//   issue_valid              : tile presented on ip_base/wt_base
//   ip_base, wt_base         : first slot of the tile on each side
//   ip_mask, wt_mask         : lane-valid masks (0 when no tile presented)
//   first_tile               : first tile of the pass (clear temp accumulators)
//   ips_offset, wts_offset   : coordinate offsets
//   reduce_en                : one-cycle reduction pulse
//   busy                     : scheduler not idle
//   done                     : one-cycle completion pulse
//
// Build option SCNN_SCHED_PERF_EN adds tile_count (accepted tiles) and
// stall_count (ISSUE cycles with issue_ready low), cleared on accepted start.
// ----------------------------------------------------------------------------
module scnn_pe_sched
    import scnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IP_IDX_W-1:0] num_nz_ips,
    input  logic [WT_IDX_W-1:0] num_nz_wts,
    input  logic [IP_IDX_W-1:0] last_ip_ind,
    input  logic [WT_IDX_W-1:0] last_wt_ind,
    input  logic                issue_ready,
    output logic                issue_valid,
    output logic [IP_IDX_W-1:0] ip_base,
    output logic [WT_IDX_W-1:0] wt_base,
    output logic [TILE-1:0]     ip_mask,
    output logic [TILE-1:0]     wt_mask,
    output logic                first_tile,
    output logic [IP_IDX_W-1:0] ips_offset,
    output logic [WT_IDX_W-1:0] wts_offset,
    output logic                reduce_en,
    output logic                busy,
    output logic                done
`ifdef SCNN_SCHED_PERF_EN
    ,
    output logic [7:0]          tile_count,
    output logic [15:0]         stall_count
`endif
);

    sched_state_t        state_q, state_d;
    logic [IP_IDX_W-1:0] nz_ips_q, nz_ips_d;
    logic [WT_IDX_W-1:0] nz_wts_q, nz_wts_d;
    logic [IP_IDX_W-1:0] ip_base_q, ip_base_d;
    logic [WT_IDX_W-1:0] wt_base_q, wt_base_d;
    logic [IP_IDX_W-1:0] ips_off_q, ips_off_d;
    logic [WT_IDX_W-1:0] wts_off_q, wts_off_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;

    // One guard bit so base+TILE compares correctly near the top of range.
    logic [IP_IDX_W:0] ip_next;
    logic [WT_IDX_W:0] wt_next;
    logic              more_ips, more_wts;

    assign ip_next  = {1'b0, ip_base_q} + (IP_IDX_W+1)'(TILE);
    assign wt_next  = {1'b0, wt_base_q} + (WT_IDX_W+1)'(TILE);
    assign more_ips = ip_next < {1'b0, nz_ips_q};
    assign more_wts = wt_next < {1'b0, nz_wts_q};

    always_comb begin
        state_d     = state_q;
        nz_ips_d    = nz_ips_q;
        nz_wts_d    = nz_wts_q;
        ip_base_d   = ip_base_q;
        wt_base_d   = wt_base_q;
        ips_off_d   = ips_off_q;
        wts_off_d   = wts_off_q;
        drain_d     = drain_q;
        issue_valid = 1'b0;
        reduce_en   = 1'b0;
        done        = 1'b0;
        busy        = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nz_ips_d = num_nz_ips;
                    nz_wts_d = num_nz_wts;
                    // An empty operand set has no tiles and nothing to reduce.
                    if (num_nz_ips != '0 && num_nz_wts != '0) begin
                        state_d   = ISSUE;
                        ip_base_d = '0;
                        wt_base_d = '0;
                        ips_off_d = '0;
                        wts_off_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) begin
                    if (more_wts) begin
                        wt_base_d = wt_next[WT_IDX_W-1:0];
                        wts_off_d = last_wt_ind + WT_IDX_W'(1);
                    end else if (more_ips) begin
                        ip_base_d = ip_next[IP_IDX_W-1:0];
                        wt_base_d = '0;
                        ips_off_d = last_ip_ind + IP_IDX_W'(1);
                        wts_off_d = '0;
                    end else begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
                    state_d = REDUCE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            REDUCE: begin
                reduce_en = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= IDLE;
            nz_ips_q  <= '0;
            nz_wts_q  <= '0;
            ip_base_q <= '0;
            wt_base_q <= '0;
            ips_off_q <= '0;
            wts_off_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            nz_ips_q  <= nz_ips_d;
            nz_wts_q  <= nz_wts_d;
            ip_base_q <= ip_base_d;
            wt_base_q <= wt_base_d;
            ips_off_q <= ips_off_d;
            wts_off_q <= wts_off_d;
            drain_q   <= drain_d;
        end
    end

    logic [TILE-1:0] ip_mask_raw, wt_mask_raw;

    scnn_lane_mask #(.W(IP_IDX_W)) u_ip_mask (
        .base_i  (ip_base_q),
        .count_i (nz_ips_q),
        .mask_o  (ip_mask_raw)
    );

    scnn_lane_mask #(.W(WT_IDX_W)) u_wt_mask (
        .base_i  (wt_base_q),
        .count_i (nz_wts_q),
        .mask_o  (wt_mask_raw)
    );

    assign ip_base    = ip_base_q;
    assign wt_base    = wt_base_q;
    assign ips_offset = ips_off_q;
    assign wts_offset = wts_off_q;
    assign ip_mask    = issue_valid ? ip_mask_raw : '0;
    assign wt_mask    = issue_valid ? wt_mask_raw : '0;
    assign first_tile = issue_valid && (ip_base_q == '0) && (wt_base_q == '0);

`ifdef SCNN_SCHED_PERF_EN
    logic [7:0]  tile_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            tile_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            if (issue_ready) tile_cnt_q  <= tile_cnt_q + 8'd1;
            else             stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign tile_count  = tile_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_scnn_pe_sched.sv
// ----------------------------------------------------------------------------
// tb_scnn_pe_sched
// Directed bench for scnn_pe_sched: a table of whole passes (counts, stall
// and stray-start stimulus, hand-computed tile count and done cycle), each
// tile checked against the expected traversal, plus reset sequences.
// ----------------------------------------------------------------------------
module tb_scnn_pe_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] num_nz_ips;
    logic [3:0] num_nz_wts;
    logic [4:0] last_ip_ind;
    logic [3:0] last_wt_ind;
    logic       issue_ready;
    logic       issue_valid;
    logic [4:0] ip_base;
    logic [3:0] wt_base;
    logic [3:0] ip_mask;
    logic [3:0] wt_mask;
    logic       first_tile;
    logic [4:0] ips_offset;
    logic [3:0] wts_offset;
    logic       reduce_en;
    logic       busy;
    logic       done;
`ifdef SCNN_SCHED_PERF_EN
    logic [7:0]  tile_count;
    logic [15:0] stall_count;
`endif

    scnn_pe_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_nz_ips  (num_nz_ips),
        .num_nz_wts  (num_nz_wts),
        .last_ip_ind (last_ip_ind),
        .last_wt_ind (last_wt_ind),
        .issue_ready (issue_ready),
        .issue_valid (issue_valid),
        .ip_base     (ip_base),
        .wt_base     (wt_base),
        .ip_mask     (ip_mask),
        .wt_mask     (wt_mask),
        .first_tile  (first_tile),
        .ips_offset  (ips_offset),
        .wts_offset  (wts_offset),
        .reduce_en   (reduce_en),
        .busy        (busy),
        .done        (done)
`ifdef SCNN_SCHED_PERF_EN
        ,
        .tile_count  (tile_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    localparam int LIP = 10;  // last_ip_ind held during every pass
    localparam int LWT = 6;   // last_wt_ind held during every pass

    typedef struct {
        int ips;
        int wts;
        int stall_tile;   // tile index held with issue_ready low, -1 none
        int stall_len;
        int extra_start;  // cycle in which a stray start is pulsed, 0 none
        int exp_tiles;
        int exp_done;     // cycle of done, start sampled at edge 0
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lane_mask(input int base, input int cnt);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) m[k] = (base + k) < cnt;
        return m;
    endfunction

    function automatic logic [30:0] all_outs();
        return {issue_valid, ip_base, wt_base, ip_mask, wt_mask, first_tile,
                ips_offset, wts_offset, reduce_en, busy, done};
    endfunction

    task automatic run_pass(input int id, input vec_t v);
        int nwc, t, stalls, done_cyc, red_cyc, red_n, done_n, row, col;
        logic [31:0] exp_tile;
        nwc = (v.wts + 3) / 4;
        t = 0; stalls = v.stall_len;
        done_cyc = -1; red_cyc = -1; red_n = 0; done_n = 0;

        @(negedge clk);
        start = 1'b1; num_nz_ips = 5'(v.ips); num_nz_wts = 4'(v.wts); issue_ready = 1'b1;
        @(negedge clk);
        // Counts change after start to show the pass uses the latched values.
        start = 1'b0; num_nz_ips = 5'd1; num_nz_wts = 4'd1;

        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            start       = (cyc == v.extra_start);
            issue_ready = !(t == v.stall_tile && stalls > 0);
            #1;
            if (issue_valid) begin
                if (t >= v.exp_tiles) begin
                    check($sformatf("p%0d extra tile c%0d", id, cyc), 64'(t), 64'(v.exp_tiles - 1));
                end else begin
                    row = t / nwc; col = t % nwc;
                    exp_tile = {5'(row * 4), 4'(col * 4),
                                lane_mask(row * 4, v.ips), lane_mask(col * 4, v.wts),
                                1'(t == 0),
                                5'(row == 0 ? 0 : LIP + 1), 4'(col == 0 ? 0 : LWT + 1)};
                    check($sformatf("p%0d tile%0d c%0d", id, t, cyc),
                          64'({ip_base, wt_base, ip_mask, wt_mask, first_tile, ips_offset, wts_offset}),
                          64'(exp_tile));
                end
                if (issue_ready) t++;
                else stalls--;
            end
            if (reduce_en) begin red_n++; red_cyc = cyc; end
            if (done) begin done_n++; done_cyc = cyc; end
            @(negedge clk);
        end
        start = 1'b0;
        #1;

        if (done_cyc < 0) $display("FAIL p%0d timeout: no done within 300 cycles", id);
        check($sformatf("p%0d tiles", id), 64'(t), 64'(v.exp_tiles));
        check($sformatf("p%0d done cycle", id), 64'(done_cyc), 64'(v.exp_done));
        check($sformatf("p%0d done pulses", id), 64'(done_n), 64'd1);
        check($sformatf("p%0d reduce pulses", id), 64'(red_n), 64'(v.exp_tiles > 0 ? 1 : 0));
        if (v.exp_tiles > 0)
            check($sformatf("p%0d reduce cycle", id), 64'(red_cyc), 64'(v.exp_done - 1));
        check($sformatf("p%0d idle after done", id), 64'({busy, issue_valid}), 64'd0);
`ifdef SCNN_SCHED_PERF_EN
        check($sformatf("p%0d tile_count", id), 64'(tile_count), 64'(v.exp_tiles));
        check($sformatf("p%0d stall_count", id), 64'(stall_count), 64'(v.stall_len));
`endif
    endtask

    vec_t vecs[9];

    initial begin
        int done_seen;
        vecs[0] = '{16, 9, -1, 0, 0, 12, 16};  // full pass, 3 weight tiles per row
        vecs[1] = '{ 5, 3, -1, 0, 0,  2,  6};  // partial masks on both sides
        vecs[2] = '{ 8, 8,  1, 3, 0,  4, 11};  // tile 1 stalled 3 cycles
        vecs[3] = '{ 0, 9, -1, 0, 0,  0,  1};  // zero inputs
        vecs[4] = '{ 7, 0, -1, 0, 0,  0,  1};  // zero weights
        vecs[5] = '{ 1, 1, -1, 0, 0,  1,  5};  // single-lane tile
        vecs[6] = '{13, 5, -1, 0, 0,  8, 12};
        vecs[7] = '{ 8, 4, -1, 0, 3,  2,  6};  // stray start while busy
        vecs[8] = '{ 4, 4, -1, 0, 5,  1,  5};  // start in the done cycle

        rst = 1'b1; start = 1'b0; issue_ready = 1'b0;
        num_nz_ips = '0; num_nz_wts = '0;
        last_ip_ind = 5'(LIP); last_wt_ind = 4'(LWT);
        @(negedge clk); @(negedge clk);
        check("reset outputs", 64'(all_outs()), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_pass(i, vecs[i]);

        // Reset while the third tile of a long pass is presented.
        @(negedge clk);
        start = 1'b1; num_nz_ips = 5'd16; num_nz_wts = 4'd9; issue_ready = 1'b1;
        @(negedge clk); start = 1'b0;   // cycle 1: tile 0
        @(negedge clk);                 // cycle 2: tile 1
        @(negedge clk);                 // cycle 3: tile 2
        #1;
        check("mid-pass third tile", 64'({issue_valid, ip_base, wt_base}), 64'({1'b1, 5'd0, 4'd8}));
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid-pass reset outputs", 64'(all_outs()), 64'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (done || reduce_en || busy) done_seen++;
        end
        check("no activity after reset", 64'(done_seen), 64'd0);
        run_pass(9, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/scnn_pe_sched.md
# scnn_pe_sched

Sequencing controller for the SCNN processing element. It walks the Cartesian product of compressed inputs and compressed weights in 4×4 tiles, and drives the multiplier array's operand fetch with tile base pointers and lane-valid masks. It manages the coordinate-unit offsets, waits out the multiply/scatter pipeline, then triggers the final accumulator reduction and reports completion. It replaces the free-running counter/stop/final_flag logic inside the PE with an explicit, resettable, back-pressurable FSM.

## Interface
- TILE, 4, lanes per operand side of the multiplier array
- IP_MAX, 16, maximum non-zero inputs per PE
- WT_MAX, 9, maximum non-zero weights per PE
- PIPE_LAT, 2, cycles from tile issue to last scatter write into the temp accumulators

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begin one convolution pass
- num_nz_ips  in  5  non-zero input count, 0..16
- num_nz_wts  in  4  non-zero weight count, 0..9
- last_ip_ind  in  5  last decoded input index from the coordinate unit
- last_wt_ind  in  4  last decoded weight index from the coordinate unit
- issue_ready  in  1  datapath can accept a tile this cycle
- issue_valid  out  1  tile presented on ip_base/wt_base
- ip_base  out  5  first compressed-input slot of the tile
- wt_base  out  4  first compressed-weight slot of the tile
- ip_mask  out  4  lane k valid when ip_base+k < num_nz_ips
- wt_mask  out  4  lane k valid when wt_base+k < num_nz_wts
- first_tile  out  1  high with the first tile of a pass; datapath clears its temp accumulators
- ips_offset  out  5  input coordinate offset
- wts_offset  out  4  weight coordinate offset
- reduce_en  out  1  one-cycle pulse; datapath sums temp buffers into the output buffer
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, DRAIN, REDUCE, DONE.
- IDLE:
  - start with both counts non-zero → ISSUE; ip_base=0, wt_base=0, offsets=0. Counts are latched internally.
  - start with either count zero → DONE. No tile is issued and reduce_en is not raised.
  - start is ignored in every other state.
- ISSUE:
  - issue_valid=1. A tile is accepted on issue_valid && issue_ready.
  - On accept, if wt_base+TILE < num_nz_wts: wt_base += TILE and wts_offset <= last_wt_ind+1.
  - Otherwise, if ip_base+TILE < num_nz_ips: ip_base += TILE, wt_base <= 0, ips_offset <= last_ip_ind+1, wts_offset <= 0.
  - Otherwise the tile was the last one → DRAIN.
  - issue_ready low holds all outputs and state unchanged.
- Traversal order: weights inner, inputs outer. Tile count = ceil(ips/4)·ceil(wts/4).
- DRAIN: count PIPE_LAT cycles, then → REDUCE.
- REDUCE: reduce_en=1 for exactly one cycle → DONE.
- DONE: done=1 for one cycle → IDLE.
- Masks are combinational from the latched counts and the bases, and are valid whenever issue_valid=1; they are 0 otherwise.
- first_tile=1 only while issuing the tile with ip_base=0 and wt_base=0.

## Timing
- Reset: state IDLE. All outputs 0: issue_valid, ip_base, wt_base, ip_mask, wt_mask, first_tile, ips_offset, wts_offset, reduce_en, busy, done. The drain counter is also 0.
- Reset during any state aborts the pass on the next edge with no done or reduce_en pulse.
- start sampled at edge N → issue_valid=1 and busy=1 from cycle N+1.
- With issue_ready held high, one tile issues per cycle.
- Last tile accepted at cycle T → DRAIN for T+1..T+PIPE_LAT, reduce_en at T+PIPE_LAT+1, done at T+PIPE_LAT+2, busy low at T+PIPE_LAT+3.
- Offsets update on the edge that accepts a tile, so they are valid in the cycle of the following tile.
- A start in the same cycle as done is ignored. A new start is accepted from IDLE only.

## Configuration
- SCNN_SCHED_PERF_EN defined:
  - Adds outputs tile_count (8 bits, accepted tiles this pass) and stall_count (16 bits, ISSUE cycles with issue_ready=0).
  - Both counters clear on an accepted start and on rst, and hold after done.
- Not defined: these ports and counters are absent. Functional behaviour is identical.

## Structure
- Package scnn_pkg holds:
  - the state enum sched_state_t
  - constants TILE, IP_MAX, WT_MAX
  - index width localparams IP_IDX_W=5 and WT_IDX_W=4
- One sub-module, scnn_lane_mask. It is combinational: (base, count) → 4-bit mask. It is instantiated twice, once per side.
- The FSM, counters and offsets stay in scnn_pe_sched.

## Test plan
- ips=16, wts=9, ready=1, start at cycle 0:
  - 12 tiles in cycles 1–12.
  - wt_base sequence per row 0,4,8. wt_mask 1111,1111,0001. ip_mask always 1111.
  - reduce_en at 15, done at 16.
- ips=5, wts=3: 2 tiles.
  - (0,0) with masks ip 1111, wt 0111.
  - (4,0) with masks ip 0001, wt 0111. ips_offset = last_ip_ind+1 on the second tile.
- ips=8, wts=8, issue_ready low for 3 cycles on the second tile → tile held stable, done delayed by exactly 3 cycles.
  - With SCNN_SCHED_PERF_EN: stall_count=3 and tile_count=4.
- ips=0, wts=9, start → no issue_valid or reduce_en; done one cycle after DONE entry.
- rst asserted mid-ISSUE on the 3rd tile → all outputs 0 next cycle, no done pulse. A following start runs a full pass cleanly.
- start pulsed while busy → ignored; the tile sequence and done timing are unchanged.
